// File: rtl/counter_reg_pkg.sv
// ============================================================================
// Module : counter_reg_pkg
// Brief  : Shared width defaults for the counter/shift-register block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_reg_pkg;

    localparam int CNT_W_DEF = 3;
    localparam int SR_W_DEF  = 8;

endpackage : counter_reg_pkg

`default_nettype wire

// File: rtl/counter_reg_if.sv
// ============================================================================
// Module : counter_reg_if
// Brief  : Control and status bundle between a driver and counter_reg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface counter_reg_if
    import counter_reg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SR_W  = SR_W_DEF
);

    logic             set;
    logic             enable;
    logic             serialin;
    logic [CNT_W-1:0] q;
    logic [SR_W-1:0]  serialout;
    logic             co;

    modport master (
        output set,
        output enable,
        output serialin,
        input  q,
        input  serialout,
        input  co
    );

    modport slave (
        input  set,
        input  enable,
        input  serialin,
        output q,
        output serialout,
        output co
    );

endinterface : counter_reg_if

`default_nettype wire

// File: rtl/counter_reg_shift.sv
// ============================================================================
// Module : counter_reg_shift
// Brief  : Enabled serial-in/parallel-out shift register, newest bit at LSB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_reg_shift
    import counter_reg_pkg::*;
#(
    parameter int SR_W = SR_W_DEF
) (
    input  wire logic            clock,
    input  wire logic            reset,
    input  wire logic            enable,
    input  wire logic            serialin,
    output      logic [SR_W-1:0] serialout
);

    logic [SR_W-1:0] r_sr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sr <= '0;
        end else if (enable) begin
            r_sr <= {r_sr[SR_W-2:0], serialin};
        end
    end

    assign serialout = r_sr;

endmodule : counter_reg_shift

`default_nettype wire

// File: rtl/counter_reg.sv
// ============================================================================
// Module : counter_reg
// Brief  : Presettable wrapping counter with carry-out plus serial shifter.
//          Define COUNTER_REG_CO_REG_EN for a registered one-cycle carry-out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_reg
    import counter_reg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SR_W  = SR_W_DEF
) (
    input  wire logic  clock,
    input  wire logic  reset,
    counter_reg_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_q;
    logic [SR_W-1:0]  w_serialout;
    logic             w_q_max;
    logic             w_co;

    // Preset wins over counting; a preset does not touch the shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (bus.set) begin
            r_q <= c_cnt_max;
        end else if (bus.enable) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign w_q_max = (r_q == c_cnt_max);

`ifdef COUNTER_REG_CO_REG_EN
    logic r_co;

    // Flags the edge where the counter actually wraps from all ones to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_co <= 1'b0;
        end else begin
            r_co <= bus.enable & ~bus.set & w_q_max;
        end
    end

    assign w_co = r_co;
`else
    assign w_co = reset & bus.enable & w_q_max;
`endif

    counter_reg_shift #(
        .SR_W (SR_W)
    ) u_shift (
        .clock     (clock),
        .reset     (reset),
        .enable    (bus.enable),
        .serialin  (bus.serialin),
        .serialout (w_serialout)
    );

    assign bus.q         = r_q;
    assign bus.serialout = w_serialout;
    assign bus.co        = w_co;

endmodule : counter_reg

`default_nettype wire

// File: tb/tb_counter_reg.sv
// ============================================================================
// Module : tb_counter_reg
// Brief  : Self-checking bench for counter_reg against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_reg;

    localparam int CNT_W   = 3;
    localparam int SR_W    = 8;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int CNT_MAX = CNT_MOD - 1;
    localparam int SR_MASK = (1 << SR_W) - 1;

    logic clock;
    logic reset;

    counter_reg_if #(.CNT_W(CNT_W), .SR_W(SR_W)) bus ();

    counter_reg #(
        .CNT_W (CNT_W),
        .SR_W  (SR_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: plain integers following the counting/shifting rules.
    int q_m;
    int sr_m;
    int co_reg_m;

    function automatic int co_expected(input int en);
`ifdef COUNTER_REG_CO_REG_EN
        return co_reg_m;
`else
        return (reset === 1'b1 && en != 0 && q_m == CNT_MAX) ? 1 : 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int en);
        chk({tag, ".q"},         32'(bus.q),         32'(q_m));
        chk({tag, ".serialout"}, 32'(bus.serialout), 32'(sr_m));
        chk({tag, ".co"},        32'(bus.co),        32'(co_expected(en)));
    endtask

    task automatic model_reset();
        q_m      = 0;
        sr_m     = 0;
        co_reg_m = 0;
    endtask

    // Drive inputs mid-cycle, check pre-edge carry, clock once, check state.
    task automatic tick(input string tag, input logic s, input logic e, input logic d);
        bus.set      = s;
        bus.enable   = e;
        bus.serialin = d;
        #1;
        chk({tag, ".co_pre"}, 32'(bus.co), 32'(co_expected(int'(e))));
        @(posedge clock);
        if (reset === 1'b1) begin
            co_reg_m = (e && !s && q_m == CNT_MAX) ? 1 : 0;
            if (s)      q_m = CNT_MAX;
            else if (e) q_m = (q_m + 1) % CNT_MOD;
            if (e)      sr_m = ((sr_m << 1) | int'(d)) & SR_MASK;
        end
        #1;
        chk_all(tag, int'(e));
    endtask

    initial begin
        logic [7:0] pat;
        reset        = 1'b0;
        bus.set      = 1'b0;
        bus.enable   = 1'b1;
        bus.serialin = 1'b1;
        model_reset();

        // Reset is visible before any clock edge.
        #2;
        chk_all("t0_reset", 1);
        tick("in_reset", 1'b1, 1'b1, 1'b1);
        reset = 1'b1;

        // Preset with enable, then wrap to zero.
        tick("preset", 1'b1, 1'b1, 1'b0);
        chk("preset_q7", 32'(bus.q), 32'd7);
        tick("wrap", 1'b0, 1'b1, 1'b0);
        chk("wrap_q0", 32'(bus.q), 32'd0);

        // Eight-bit fill from zero.
        pat = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) tick("fill", 1'b0, 1'b1, pat[i]);
        chk("fill_B2", 32'(bus.serialout), 32'hB2);
        chk("fill_q0", 32'(bus.q), 32'd0);

        // Hold with toggling data.
        for (int i = 0; i < 3; i++) tick("hold", 1'b0, 1'b0, i[0]);
        chk("hold_B2", 32'(bus.serialout), 32'hB2);

        // Reach q=5, serialout=2D, then reset between edges.
        tick("pre5", 1'b1, 1'b1, 1'b0);
        pat = 8'b0010_1101;
        for (int i = 5; i >= 0; i--) tick("to5", 1'b0, 1'b1, pat[i]);
        chk("mid_q5",  32'(bus.q),         32'd5);
        chk("mid_2D",  32'(bus.serialout), 32'h2D);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_all("async_reset", 1);
        @(negedge clock);
        reset = 1'b1;

        // Count 6 -> 7 -> 0 and watch the carry around the wrap.
        for (int i = 0; i < 6; i++) tick("to6", 1'b0, 1'b1, 1'b1);
        chk("at6", 32'(bus.q), 32'd6);
        tick("6to7", 1'b0, 1'b1, 1'b0);
        tick("7to0", 1'b0, 1'b1, 1'b0);
        tick("after0", 1'b0, 1'b1, 1'b1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #1;
                reset = 1'b0;
                model_reset();
                #1;
                chk_all("rnd_reset", int'(bus.enable));
                tick("rnd_in_reset", 1'($urandom), 1'($urandom), 1'($urandom));
                @(negedge clock);
                reset = 1'b1;
            end
            tick("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_counter_reg

`default_nettype wire

// File: doc/counter_reg.md
COUNTER_REG -- requirements
Module: counter_reg

Interface
REQ-001 Parameter CNT_W, default 3: counter width; q width.
REQ-002 Parameter SR_W, default 8: shift-register width; serialout width.
REQ-003 Port clock  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port set  input  1: synchronous counter preset request, active-high.
REQ-006 Port enable  input  1: count/shift enable, active-high.
REQ-007 Port serialin  input  1: serial data bit shifted into the register.
REQ-008 Port q  output  CNT_W: current counter value.
REQ-009 Port serialout  output  SR_W: parallel view of the shift register.
REQ-010 Port co  output  1: carry-out, active-high.

Function
REQ-011 Counter priority per rising edge SHALL be: set, then enable, then hold.
REQ-012 set=1 SHALL load q to all ones (3'b111 at default), regardless of enable.
REQ-013 set=0, enable=1 SHALL increment q by 1 modulo 2^CNT_W; 7 wraps to 0.
REQ-014 set=0, enable=0 SHALL hold q.
REQ-015 With enable=1, shift register SHALL update serialout <= {serialout[SR_W-2:0], serialin}, MSB first out, newest bit at bit 0.
REQ-016 With enable=0, serialout SHALL hold; set SHALL NOT affect serialout.
REQ-017 co SHALL be combinational: co = enable & (q == all ones), no clock latency (default build).
REQ-018 At default widths, 8 consecutive enabled cycles from q=0 SHALL fill serialout with 8 fresh bits; co SHALL be high during the eighth.
REQ-019 Simultaneous set and enable: q loads all ones; serialout still shifts.

Reset
REQ-020 reset=0 SHALL immediately force q=0 and serialout=0, independent of clock.
REQ-021 While reset=0, co SHALL be 0 and set/enable/serialin SHALL be ignored.
REQ-022 Release of reset (0->1) SHALL take effect from the next rising edge; no synchronizer inside the block.
REQ-023 Reset asserted mid-count SHALL discard partial serial data.

Configuration
REQ-024 Macro COUNTER_REG_CO_REG_EN defined: co SHALL be a flop, set on the edge where q changes from all ones to 0 under enable; high one full cycle; reset to 0.
REQ-025 Macro undefined: co SHALL follow REQ-017 (combinational).

Structure
REQ-026 Package counter_reg_pkg SHALL hold default width constants CNT_W_DEF=3, SR_W_DEF=8.
REQ-027 Shift register SHALL be a sub-module counter_reg_shift (clock, reset, enable, serialin, serialout) instantiated once.
REQ-028 Counter and co logic SHALL reside in counter_reg top level.

Verification
REQ-029 reset=0 at t0 with clock running -> q=0, serialout=8'h00, co=0 immediately, no edge needed.
REQ-030 reset=1, enable=1, set=1 one edge -> q=3'b111; set=0 next edge -> q=0 (wrap); default build co=1 before that edge.
REQ-031 From q=0, enable=1, serialin pattern 1,0,1,1,0,0,1,0 over 8 edges -> serialout=8'hB2, q=0 after the eighth edge.
REQ-032 enable=0 for 3 edges with toggling serialin and set=0 -> q and serialout unchanged, co=0.
REQ-033 Pull reset low mid-sequence (q=5, serialout=8'h2D) between edges -> q=0, serialout=0 instantly.
REQ-034 Build with COUNTER_REG_CO_REG_EN, count 6->7->0 -> co=1 only in the cycle after the 7->0 edge.
